// File: rtl/axis_parser_pkg.sv
// axis_parser shared definitions: FSM encoding and
// header/residual byte-count helpers.
package axis_parser_pkg;

  localparam int ST_WIDTH = 2;

  typedef enum logic [ST_WIDTH-1:0] {
    ST_HDR0,
    ST_HDR1,
    ST_PAYLOAD,
    ST_FLUSH
  } state_t;

  function automatic int resd_bytes(
    input int hdr_keep,
    input int s_keep
  );
    return hdr_keep - s_keep;
  endfunction

  function automatic int res_bytes(
    input int hdr_keep,
    input int s_keep
  );
    return 2 * s_keep - hdr_keep;
  endfunction

endpackage

// File: rtl/axis_parser_if.sv
// AXI-Stream bundle with master/slave modports,
// used for the packet input and both outputs.
interface axis_parser_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 4
);

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast,
    output tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast,
    input  tid, tdest, tuser,
    output tready
  );

endinterface

// File: rtl/axis_parser_skid_reg.sv
// Two-entry AXI-Stream register slice; s_tready is
// registered so it never depends on m_tready combinationally.
module axis_skid_reg #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [KEEP_WIDTH-1:0] s_tkeep,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [ID_WIDTH-1:0]   s_tid,
  input  logic [DEST_WIDTH-1:0] s_tdest,
  input  logic [USER_WIDTH-1:0] s_tuser,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [KEEP_WIDTH-1:0] m_tkeep,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [ID_WIDTH-1:0]   m_tid,
  output logic [DEST_WIDTH-1:0] m_tdest,
  output logic [USER_WIDTH-1:0] m_tuser
);

  localparam int W = DATA_WIDTH + KEEP_WIDTH + 1
                   + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  logic [W-1:0] in_bus;
  logic [W-1:0] out_reg;
  logic [W-1:0] tmp_reg;
  logic         tmp_valid;
  logic         ready_early;

  assign in_bus = {s_tdata, s_tkeep, s_tlast,
                   s_tid, s_tdest, s_tuser};
  assign {m_tdata, m_tkeep, m_tlast,
          m_tid, m_tdest, m_tuser} = out_reg;

  // accept next cycle unless the temp slot is about to fill
  assign ready_early = m_tready ||
    (!tmp_valid && (!m_tvalid || !s_tvalid));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_tready  <= 1'b0;
      m_tvalid  <= 1'b0;
      tmp_valid <= 1'b0;
      out_reg   <= '0;
      tmp_reg   <= '0;
    end else begin
      s_tready <= ready_early;
      if (s_tready) begin
        if (m_tready || !m_tvalid) begin
          m_tvalid <= s_tvalid;
          if (s_tvalid) out_reg <= in_bus;
        end else begin
          tmp_valid <= s_tvalid;
          if (s_tvalid) tmp_reg <= in_bus;
        end
      end else if (m_tready) begin
        m_tvalid  <= tmp_valid;
        out_reg   <= tmp_reg;
        tmp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axis_parser.sv
// Splits each packet into a fixed-size header beat and
// an LSB-realigned payload stream.
module axis_parser
  import axis_parser_pkg::*;
#(
  parameter int S_DATA_WIDTH   = 512,
  parameter int S_KEEP_WIDTH   = S_DATA_WIDTH / 8,
  parameter int S_ID_WIDTH     = 8,
  parameter int S_DEST_WIDTH   = 4,
  parameter int S_USER_WIDTH   = 4,
  parameter int HDR_DATA_WIDTH = 560
) (
  input  logic          clk,
  input  logic          rst,
  axis_parser_if.slave  s_axis,
  axis_parser_if.master m_axis_hdr,
  axis_parser_if.master m_axis
);

  localparam int HDR_KEEP_WIDTH = HDR_DATA_WIDTH / 8;
  localparam int RESD =
    resd_bytes(HDR_KEEP_WIDTH, S_KEEP_WIDTH);
  localparam int RES_BYTES =
    res_bytes(HDR_KEEP_WIDTH, S_KEEP_WIDTH);

  if (S_DATA_WIDTH % 8 != 0 ||
      !(S_DATA_WIDTH < HDR_DATA_WIDTH &&
        HDR_DATA_WIDTH <= 2 * S_DATA_WIDTH)) begin : g_bad
    $error("axis_parser: bad S/HDR data widths");
  end

  state_t state;

  logic [S_DATA_WIDTH-1:0]   hdr_lo;
  logic [S_KEEP_WIDTH-1:0]   hdr_lo_keep;
  logic [S_DATA_WIDTH-1:0]   res_data;
  logic [S_KEEP_WIDTH-1:0]   res_keep;
  logic [S_KEEP_WIDTH-1:0]   res_keep_nxt;
  logic [S_ID_WIDTH-1:0]     id_q, cur_id;
  logic [S_DEST_WIDTH-1:0]   dest_q, cur_dest;
  logic [S_USER_WIDTH-1:0]   user_q, cur_user;
  logic [HDR_DATA_WIDTH-1:0] hdr_data;
  logic [HDR_KEEP_WIDTH-1:0] hdr_keep;
  logic [S_DATA_WIDTH-1:0]   pay_data;
  logic [S_KEEP_WIDTH-1:0]   pay_keep;
  logic hdr_wr, hdr_rdy;
  logic pay_wr, pay_rdy, pay_last;
  logic s_ready, beat, res_empty;

  assign s_axis.tready = s_ready;
  assign beat          = s_axis.tvalid && s_ready;
  assign res_keep_nxt  = s_axis.tkeep >> RESD;
  assign res_empty     = res_keep_nxt == '0;

  // first beat's sideband is used directly in ST_HDR0
  assign cur_id   = (state == ST_HDR0) ? s_axis.tid   : id_q;
  assign cur_dest = (state == ST_HDR0) ? s_axis.tdest : dest_q;
  assign cur_user = (state == ST_HDR0) ? s_axis.tuser : user_q;

  always_comb begin
    s_ready = 1'b0;
    unique case (state)
      ST_HDR0, ST_HDR1: s_ready = hdr_rdy && pay_rdy;
      ST_PAYLOAD:       s_ready = pay_rdy;
      ST_FLUSH:         s_ready = 1'b0;
    endcase
  end

  always_comb begin
    hdr_wr   = 1'b0;
    hdr_data = '0;
    hdr_keep = '0;
    pay_wr   = 1'b0;
    pay_data = '0;
    pay_keep = '0;
    pay_last = 1'b1;
    unique case (state)
      ST_HDR0: begin
        hdr_data = HDR_DATA_WIDTH'(s_axis.tdata);
        hdr_keep = HDR_KEEP_WIDTH'(s_axis.tkeep);
        hdr_wr   = beat && s_axis.tlast;
        pay_wr   = beat && s_axis.tlast;
      end
      ST_HDR1: begin
        hdr_data = HDR_DATA_WIDTH'({s_axis.tdata, hdr_lo});
        hdr_keep = HDR_KEEP_WIDTH'({s_axis.tkeep, hdr_lo_keep});
        hdr_wr   = beat;
        pay_wr   = beat && s_axis.tlast && res_empty;
      end
      ST_PAYLOAD: begin
        pay_data = res_data |
          (s_axis.tdata << (RES_BYTES * 8));
        pay_keep = res_keep |
          (s_axis.tkeep << RES_BYTES);
        pay_wr   = beat;
        pay_last = s_axis.tlast && res_empty;
      end
      ST_FLUSH: begin
        pay_data = res_data;
        pay_keep = res_keep;
        pay_wr   = pay_rdy;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_HDR0;
      hdr_lo      <= '0;
      hdr_lo_keep <= '0;
      res_data    <= '0;
      res_keep    <= '0;
      id_q        <= '0;
      dest_q      <= '0;
      user_q      <= '0;
    end else begin
      unique case (state)
        ST_HDR0: if (beat) begin
          hdr_lo      <= s_axis.tdata;
          hdr_lo_keep <= s_axis.tkeep;
          id_q        <= s_axis.tid;
          dest_q      <= s_axis.tdest;
          user_q      <= s_axis.tuser;
          if (!s_axis.tlast) state <= ST_HDR1;
        end
        ST_HDR1, ST_PAYLOAD: if (beat) begin
          res_data <= s_axis.tdata >> (RESD * 8);
          res_keep <= res_keep_nxt;
          if (!s_axis.tlast) state <= ST_PAYLOAD;
          else if (res_empty) state <= ST_HDR0;
          else state <= ST_FLUSH;
        end
        ST_FLUSH: if (pay_rdy) begin
          res_keep <= '0;
          state    <= ST_HDR0;
        end
      endcase
    end
  end

  axis_skid_reg #(
    .DATA_WIDTH(HDR_DATA_WIDTH),
    .KEEP_WIDTH(HDR_KEEP_WIDTH),
    .ID_WIDTH  (S_ID_WIDTH),
    .DEST_WIDTH(S_DEST_WIDTH),
    .USER_WIDTH(S_USER_WIDTH)
  ) u_hdr (
    .clk     (clk),
    .rst     (rst),
    .s_tdata (hdr_data),
    .s_tkeep (hdr_keep),
    .s_tvalid(hdr_wr),
    .s_tready(hdr_rdy),
    .s_tlast (1'b1),
    .s_tid   (cur_id),
    .s_tdest (cur_dest),
    .s_tuser (cur_user),
    .m_tdata (m_axis_hdr.tdata),
    .m_tkeep (m_axis_hdr.tkeep),
    .m_tvalid(m_axis_hdr.tvalid),
    .m_tready(m_axis_hdr.tready),
    .m_tlast (m_axis_hdr.tlast),
    .m_tid   (m_axis_hdr.tid),
    .m_tdest (m_axis_hdr.tdest),
    .m_tuser (m_axis_hdr.tuser)
  );

  axis_skid_reg #(
    .DATA_WIDTH(S_DATA_WIDTH),
    .KEEP_WIDTH(S_KEEP_WIDTH),
    .ID_WIDTH  (S_ID_WIDTH),
    .DEST_WIDTH(S_DEST_WIDTH),
    .USER_WIDTH(S_USER_WIDTH)
  ) u_pay (
    .clk     (clk),
    .rst     (rst),
    .s_tdata (pay_data),
    .s_tkeep (pay_keep),
    .s_tvalid(pay_wr),
    .s_tready(pay_rdy),
    .s_tlast (pay_last),
    .s_tid   (cur_id),
    .s_tdest (cur_dest),
    .s_tuser (cur_user),
    .m_tdata (m_axis.tdata),
    .m_tkeep (m_axis.tkeep),
    .m_tvalid(m_axis.tvalid),
    .m_tready(m_axis.tready),
    .m_tlast (m_axis.tlast),
    .m_tid   (m_axis.tid),
    .m_tdest (m_axis.tdest),
    .m_tuser (m_axis.tuser)
  );

endmodule

// File: tb/tb_axis_parser.sv
// Scoreboard bench for axis_parser: packets in,
// expected header/payload beats queued, monitor compares.
module tb_axis_parser;

  localparam int SDW = 512;
  localparam int SKW = 64;
  localparam int HDW = 560;
  localparam int HKW = 70;

  typedef struct {
    logic [HDW-1:0] data;
    logic [HKW-1:0] keep;
    logic [15:0]    side;
  } hdr_exp_t;

  typedef struct {
    logic [SDW-1:0] data;
    logic [SKW-1:0] keep;
    logic           last;
    logic [15:0]    side;
  } pay_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axis_parser_if #(.DATA_WIDTH(SDW)) s_if ();
  axis_parser_if #(.DATA_WIDTH(HDW)) h_if ();
  axis_parser_if #(.DATA_WIDTH(SDW)) p_if ();

  axis_parser dut (
    .clk       (clk),
    .rst       (rst),
    .s_axis    (s_if),
    .m_axis_hdr(h_if),
    .m_axis    (p_if)
  );

  hdr_exp_t hq[$];
  pay_exp_t pq[$];
  int n_test = 0;
  int n_fail = 0;
  int rdy_mode = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [HDW-1:0] got,
                     input logic [HDW-1:0] want);
    n_test++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [HDW-1:0] kmask(
    input logic [HKW-1:0] k);
    logic [HDW-1:0] m;
    m = '0;
    for (int i = 0; i < HKW; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  task automatic monitor();
    hdr_exp_t he;
    pay_exp_t pe;
    logic [HDW-1:0] hm;
    logic [SDW-1:0] pm;
    forever begin
      @(negedge clk);
      if (!rst && h_if.tvalid && h_if.tready) begin
        if (hq.size() == 0) begin
          chk(0, "hdr_unexpected", HDW'(h_if.tkeep), HDW'(0));
        end else begin
          he = hq.pop_front();
          hm = h_if.tdata & kmask(he.keep);
          chk(hm == he.data, "hdr_data", hm, he.data);
          chk(h_if.tkeep == he.keep, "hdr_keep",
              HDW'(h_if.tkeep), HDW'(he.keep));
          chk(h_if.tlast == 1'b1, "hdr_last",
              HDW'(h_if.tlast), HDW'(1));
          chk({h_if.tid, h_if.tdest, h_if.tuser} == he.side,
              "hdr_side",
              HDW'({h_if.tid, h_if.tdest, h_if.tuser}),
              HDW'(he.side));
        end
      end
      if (!rst && p_if.tvalid && p_if.tready) begin
        if (pq.size() == 0) begin
          chk(0, "pay_unexpected", HDW'(p_if.tkeep), HDW'(0));
        end else begin
          pe = pq.pop_front();
          pm = p_if.tdata & SDW'(kmask(HKW'(pe.keep)));
          chk(pm == pe.data, "pay_data",
              HDW'(pm), HDW'(pe.data));
          chk(p_if.tkeep == pe.keep, "pay_keep",
              HDW'(p_if.tkeep), HDW'(pe.keep));
          chk(p_if.tlast == pe.last, "pay_last",
              HDW'(p_if.tlast), HDW'(pe.last));
          chk({p_if.tid, p_if.tdest, p_if.tuser} == pe.side,
              "pay_side",
              HDW'({p_if.tid, p_if.tdest, p_if.tuser}),
              HDW'(pe.side));
        end
      end
    end
  endtask

  task automatic rdy_drv();
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) begin
        h_if.tready = 1'b1;
        p_if.tready = 1'b1;
      end else if (rdy_mode == 1) begin
        h_if.tready = 1'($urandom_range(0, 1));
        p_if.tready = 1'($urandom_range(0, 1));
      end else begin
        h_if.tready = 1'b0;
        p_if.tready = 1'b0;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(s_if.tready == 1'b0, {tag, "_s_tready"},
        HDW'(s_if.tready), HDW'(0));
    chk(h_if.tvalid == 1'b0, {tag, "_hdr_tvalid"},
        HDW'(h_if.tvalid), HDW'(0));
    chk(p_if.tvalid == 1'b0, {tag, "_pay_tvalid"},
        HDW'(p_if.tvalid), HDW'(0));
  endtask

  task automatic send_pkt(input int len, input bit exp_out,
                          input int rst_at, input int gap);
    byte unsigned pkt[$];
    hdr_exp_t he;
    pay_exp_t pe;
    logic [15:0] side;
    int nb;
    int off;
    int n;
    side = 16'($urandom);
    for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
    if (exp_out) begin
      he.data = '0;
      he.keep = '0;
      he.side = side;
      for (int i = 0; i < len && i < HKW; i++) begin
        he.data[i*8 +: 8] = pkt[i];
        he.keep[i] = 1'b1;
      end
      hq.push_back(he);
      if (len <= HKW) begin
        pe.data = '0;
        pe.keep = '0;
        pe.last = 1'b1;
        pe.side = side;
        pq.push_back(pe);
      end else begin
        off = HKW;
        while (off < len) begin
          pe.data = '0;
          pe.keep = '0;
          pe.side = side;
          for (int j = 0; j < SKW && off + j < len; j++) begin
            pe.data[j*8 +: 8] = pkt[off+j];
            pe.keep[j] = 1'b1;
          end
          off += SKW;
          pe.last = off >= len;
          pq.push_back(pe);
        end
      end
    end
    nb = (len + SKW - 1) / SKW;
    for (int b = 0; b < nb; b++) begin
      s_if.tdata = '0;
      s_if.tkeep = '0;
      for (int j = 0; j < SKW; j++) begin
        if (b * SKW + j < len) begin
          s_if.tdata[j*8 +: 8] = pkt[b*SKW+j];
          s_if.tkeep[j] = 1'b1;
        end
      end
      s_if.tlast = (b == nb - 1);
      {s_if.tid, s_if.tdest, s_if.tuser} = side;
      s_if.tvalid = 1'b1;
      if (b == rst_at) begin
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        s_if.tvalid = 1'b0;
        #1;
        chk(s_if.tready == 1'b0, "midrst_release_tready",
            HDW'(s_if.tready), HDW'(0));
        return;
      end
      n = 0;
      while (!s_if.tready && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (!s_if.tready) begin
        chk(0, "s_tready_timeout", HDW'(0), HDW'(1));
        s_if.tvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_if.tvalid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((hq.size() != 0 || pq.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk(hq.size() == 0, {tag, "_hdr_drained"},
        HDW'(hq.size()), HDW'(0));
    chk(pq.size() == 0, {tag, "_pay_drained"},
        HDW'(pq.size()), HDW'(0));
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!s_if.tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(s_if.tready == 1'b1, {tag, "_tready_up"},
        HDW'(s_if.tready), HDW'(1));
  endtask

  int dir_len[13] = '{40, 68, 100, 134, 135, 64, 65,
                      70, 71, 128, 129, 200, 1};

  initial begin
    rst = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tid    = '0;
    s_if.tdest  = '0;
    s_if.tuser  = '0;
    h_if.tready = 1'b0;
    p_if.tready = 1'b0;
    fork
      monitor();
      rdy_drv();
    join_none
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    #1;
    chk(s_if.tready == 1'b0, "release_tready",
        HDW'(s_if.tready), HDW'(0));
    wait_ready("init");
    @(negedge clk);

    rdy_mode = 0;
    foreach (dir_len[i]) send_pkt(dir_len[i], 1'b1, -1, 0);
    drain("directed");

    rdy_mode = 1;
    for (int k = 0; k < 1000; k++)
      send_pkt($urandom_range(1, 1500), 1'b1, -1,
               $urandom_range(0, 2));
    rdy_mode = 0;
    drain("random");

    rdy_mode = 2;
    repeat (3) @(negedge clk);
    send_pkt(300, 1'b0, 2, 0);
    rdy_mode = 0;
    wait_ready("midrst");
    @(negedge clk);
    send_pkt(100, 1'b1, -1, 0);
    drain("after_rst");
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
